dram_seq: RTL and testbench

DRAM_SEQ -- requirements
Module: dram_seq

---
 rtl/dram_seq.sv | 121 ++++++++++++
 tb/tb_dram_seq.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_seq.sv
// dram_seq: DRAM access sequencer with multiplexed row/column addressing
// and CAS-before-RAS refresh scheduling, clocked from the 7.16 MHz C7M.
module dram_seq #(
  parameter int REF_INTERVAL = 26,
  parameter int REF_MAX      = 7
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        Req,
  input  logic        ReqnWE,
  input  logic [22:0] ReqAddr,
  output logic        Ready,
  output logic        Done,
  output logic        RDLatch,
  output logic [10:0] RA,
  output logic        nRAS,
  output logic        nCAS0,
  output logic        nCAS1,
  output logic        nRWE,
  output logic [2:0]  RefPend,
  output logic [3:0]  state_dbg
);

  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);
  localparam logic [2:0]    PEND_MAX   = 3'(REF_MAX);

  typedef enum logic [3:0] {
    IDLE, ROW, RAS, COL, CAS1, CAS2, RCAS, RRAS, RHOLD, PRE
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic          tick, accept, ref_start;
  logic          wr_q, bank_q;
  logic [10:0]   col_q;
  logic          cas_acc, cas_ref;
  logic          ras_nx, cas0_nx, cas1_nx, rwe_nx, rdl_nx, done_nx;
  logic [10:0]   ra_nx;

  assign state_dbg = state;

  // Handshake: Req/ReqnWE/ReqAddr are taken on a rising C7M edge only while
  // Ready is high; Ready is the sole combinational output, all others are
  // registered copies of what the next state implies.
  always_comb begin
    tick      = (timer == TIMER_LAST);
    Ready     = (state == IDLE) && (RefPend != PEND_MAX);
    accept    = Ready && Req;
    ref_start = (state == IDLE) && !accept && (RefPend != 3'd0);

    state_nx = state;
    case (state)
      IDLE: begin
        if (accept)         state_nx = ROW;
        else if (ref_start) state_nx = RCAS;
      end
      ROW:     state_nx = RAS;
      RAS:     state_nx = COL;
      COL:     state_nx = CAS1;
      CAS1:    state_nx = CAS2;
      CAS2:    state_nx = PRE;
      RCAS:    state_nx = RRAS;
      RRAS:    state_nx = RHOLD;
      RHOLD:   state_nx = PRE;
      PRE:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    cas_acc = (state_nx == CAS1) || (state_nx == CAS2);
    cas_ref = state_nx inside {RCAS, RRAS, RHOLD};
    ras_nx  = !(state_nx inside {RAS, COL, CAS1, CAS2, RRAS, RHOLD});
    cas0_nx = !(cas_ref || (cas_acc && !bank_q));
    cas1_nx = !(cas_ref || (cas_acc && bank_q));
    rwe_nx  = !(wr_q && (state_nx inside {COL, CAS1, CAS2}));
    rdl_nx  = !wr_q && (state_nx == CAS2);
    done_nx = (state == CAS2);

    // Row goes out straight from the request; column from the latched copy.
    ra_nx = RA;
    if (accept)                 ra_nx = ReqAddr[21:11];
    else if (state_nx == COL)   ra_nx = col_q;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state   <= IDLE;
      timer   <= '0;
      RefPend <= '0;
      wr_q    <= 1'b0;
      bank_q  <= 1'b0;
      col_q   <= '0;
      RA      <= '0;
      nRAS    <= 1'b1;
      nCAS0   <= 1'b1;
      nCAS1   <= 1'b1;
      nRWE    <= 1'b1;
      RDLatch <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= tick ? '0 : timer + TW'(1);
      // A tick and a refresh start on the same edge cancel out.
      if (tick && !ref_start && (RefPend != PEND_MAX)) RefPend <= RefPend + 3'd1;
      else if (!tick && ref_start)                     RefPend <= RefPend - 3'd1;
      if (accept) begin
        wr_q   <= !ReqnWE;
        bank_q <= ReqAddr[22];
        col_q  <= ReqAddr[10:0];
      end
      RA      <= ra_nx;
      nRAS    <= ras_nx;
      nCAS0   <= cas0_nx;
      nCAS1   <= cas1_nx;
      nRWE    <= rwe_nx;
      RDLatch <= rdl_nx;
      Done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_dram_seq.sv
// tb_dram_seq: directed and randomized checks of dram_seq against a
// cycle-level access/refresh model kept in the bench.
module tb_dram_seq;

  localparam int REF_INTERVAL = 26;
  localparam int REF_MAX      = 7;
  localparam int OP_IDLE = 0, OP_ACC = 1, OP_REF = 2;
  // {Ready, Done, RDLatch, RA, nRAS, nCAS0, nCAS1, nRWE, RefPend}
  localparam logic [20:0] RST_VEC = {1'b1, 1'b0, 1'b0, 11'h000, 4'b1111, 3'd0};

  logic        C7M = 1'b0;
  logic        nRES = 1'b1;
  logic        Req = 1'b0;
  logic        ReqnWE = 1'b1;
  logic [22:0] ReqAddr = '0;
  logic        Ready, Done, RDLatch, nRAS, nCAS0, nCAS1, nRWE;
  logic [10:0] RA;
  logic [2:0]  RefPend;
  logic [3:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  dram_seq #(.REF_INTERVAL(REF_INTERVAL), .REF_MAX(REF_MAX)) dut (
    .C7M(C7M), .nRES(nRES), .Req(Req), .ReqnWE(ReqnWE), .ReqAddr(ReqAddr),
    .Ready(Ready), .Done(Done), .RDLatch(RDLatch), .RA(RA), .nRAS(nRAS),
    .nCAS0(nCAS0), .nCAS1(nCAS1), .nRWE(nRWE), .RefPend(RefPend),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 C7M = ~C7M;

  // Reference model: an operation kind plus the number of edges since it began.
  int          m_timer, m_pend, m_op, m_phase;
  logic        m_we;
  logic [22:0] m_addr;
  logic [10:0] m_ra;
  int          n_timer, n_pend, n_op, n_phase;
  logic        n_we;
  logic [22:0] n_addr;
  logic [10:0] n_ra;
  logic        m_tick, m_start;
  logic        acc, rfs, e_nras, e_ncas0, e_ncas1, e_nrwe, e_rdl, e_done, e_ready;
  logic [20:0] exp_v, obs;

  assign obs = {Ready, Done, RDLatch, RA, nRAS, nCAS0, nCAS1, nRWE, RefPend};

  always_comb begin
    m_tick  = (m_timer == REF_INTERVAL - 1);
    n_timer = m_tick ? 0 : m_timer + 1;
    m_start = 1'b0;
    n_op    = m_op;
    n_phase = m_phase + 1;
    n_we    = m_we;
    n_addr  = m_addr;
    n_ra    = m_ra;
    if (m_op == OP_IDLE) begin
      n_phase = 0;
      if (m_pend != REF_MAX && Req) begin
        n_op   = OP_ACC;
        n_we   = !ReqnWE;
        n_addr = ReqAddr;
        n_ra   = ReqAddr[21:11];
      end else if (m_pend != 0) begin
        n_op    = OP_REF;
        m_start = 1'b1;
      end
    end else begin
      if (m_op == OP_ACC && n_phase == 2) n_ra = m_addr[10:0];
      if ((m_op == OP_ACC && n_phase == 6) || (m_op == OP_REF && n_phase == 4)) n_op = OP_IDLE;
    end
    if (m_tick && m_start) n_pend = m_pend;
    else if (m_tick)       n_pend = (m_pend == REF_MAX) ? m_pend : m_pend + 1;
    else if (m_start)      n_pend = m_pend - 1;
    else                   n_pend = m_pend;
  end

  always @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      m_timer <= 0; m_pend <= 0; m_op <= OP_IDLE; m_phase <= 0;
      m_we <= 1'b0; m_addr <= '0; m_ra <= '0;
    end else begin
      m_timer <= n_timer; m_pend <= n_pend; m_op <= n_op; m_phase <= n_phase;
      m_we <= n_we; m_addr <= n_addr; m_ra <= n_ra;
    end
  end

  always_comb begin
    acc     = (m_op == OP_ACC);
    rfs     = (m_op == OP_REF);
    e_nras  = !((acc && m_phase >= 1 && m_phase <= 4) || (rfs && m_phase >= 1 && m_phase <= 2));
    e_ncas0 = !((acc && !m_addr[22] && m_phase >= 3 && m_phase <= 4) || (rfs && m_phase <= 2));
    e_ncas1 = !((acc && m_addr[22] && m_phase >= 3 && m_phase <= 4) || (rfs && m_phase <= 2));
    e_nrwe  = !(acc && m_we && m_phase >= 2 && m_phase <= 4);
    e_rdl   = acc && !m_we && m_phase == 4;
    e_done  = acc && m_phase == 5;
    e_ready = (m_op == OP_IDLE) && (m_pend != REF_MAX);
    exp_v   = {e_ready, e_done, e_rdl, m_ra, e_nras, e_ncas0, e_ncas1, e_nrwe, 3'(m_pend)};
  end

  // driver tasks
  task automatic step();
    @(posedge C7M);
    #1;
  endtask

  task automatic apply_reset();
    #2 nRES = 1'b0;
    Req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge C7M);
    nRES = 1'b1;
  endtask

  task automatic test_reset();
    nRES = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", obs, RST_VEC);
    end
    checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", obs, exp_v);
    end
    Req = 1'b1; ReqnWE = 1'b0; ReqAddr = 23'($urandom);
    repeat (3) begin
      step();
      checks++;
      if (obs !== RST_VEC) begin
        failures++; $display("FAIL reset_hold got=%h exp=%h st=%0d", obs, RST_VEC, state_dbg);
      end
    end
  endtask

  task automatic test_read();
    logic ok;
    apply_reset();
    Req = 1'b1; ReqnWE = 1'b1; ReqAddr = 23'h400801;
    for (int e = 0; e <= 6; e++) begin
      step();
      Req = 1'b0; ReqnWE = 1'b0; ReqAddr = 23'($urandom);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL read_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      // bit 22 set: bank 1, so nCAS1 is the strobe that fires
      case (e)
        0:       ok = (RA == 11'h001) && nRAS && !Ready;
        1:       ok = (RA == 11'h001) && !nRAS;
        2:       ok = (RA == 11'h001) && !nRAS && nCAS0 && nCAS1;
        3:       ok = !nCAS1 && nCAS0 && !RDLatch;
        4:       ok = RDLatch && !nCAS1 && !Done;
        5:       ok = Done && !RDLatch && nRAS && nCAS0 && nCAS1;
        default: ok = !Done && Ready;
      endcase
      checks++;
      if (!(ok && nRWE)) begin
        failures++; $display("FAIL read_timing e=%0d got=%h", e, obs);
      end
    end
  endtask

  task automatic test_write();
    logic ok;
    apply_reset();
    Req = 1'b1; ReqnWE = 1'b0; ReqAddr = 23'h7FFFFF;
    for (int e = 0; e <= 6; e++) begin
      step();
      Req = 1'b0; ReqnWE = 1'b1; ReqAddr = 23'($urandom);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL write_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      case (e)
        0:       ok = (RA == 11'h7FF) && nRWE && nCAS1;
        1:       ok = !nRAS && nRWE && nCAS1;
        2:       ok = (RA == 11'h7FF) && !nRWE && nCAS1;
        3:       ok = !nRWE && !nCAS1 && !nRAS;
        4:       ok = !nRWE && !nCAS1 && !RDLatch;
        5:       ok = nRWE && nCAS1 && Done;
        default: ok = nRWE && !Done && Ready;
      endcase
      checks++;
      if (!(ok && nCAS0)) begin
        failures++; $display("FAIL write_timing e=%0d got=%h", e, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt, last_done;
    apply_reset();
    done_cnt = 0; last_done = -1;
    for (int e = 1; e <= 70; e++) begin
      Req = 1'b1; ReqnWE = 1'($urandom_range(0, 1)); ReqAddr = 23'($urandom);
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL b2b_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      if (Done) begin
        if (last_done >= 0) begin
          checks++;
          if (e - last_done != 7) begin
            failures++; $display("FAIL b2b_period got=%0d exp=7", e - last_done);
          end
        end
        last_done = e;
        done_cnt++;
      end
    end
    checks++;
    if (done_cnt != 10) begin
      failures++; $display("FAIL b2b_count got=%0d exp=10", done_cnt);
    end
  endtask

  task automatic test_saturation();
    logic saw_sat, saw_ref, saw_zero;
    int late_done;
    apply_reset();
    saw_sat = 1'b0; saw_ref = 1'b0; saw_zero = 1'b0; late_done = 0;
    for (int e = 0; e < 230; e++) begin
      Req = 1'b1; ReqnWE = 1'($urandom_range(0, 1)); ReqAddr = 23'($urandom);
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL sat_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      if (RefPend == 3'd7 && !Ready) saw_sat = 1'b1;
      if (!nCAS0 && !nCAS1) saw_ref = 1'b1;
    end
    checks++;
    if (!(saw_sat && saw_ref)) begin
      failures++; $display("FAIL sat_reached got=%b%b exp=11", saw_sat, saw_ref);
    end
    Req = 1'b0;
    for (int e = 0; e < 60; e++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL drain_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      if (e >= 7 && Done) late_done++;
      if (RefPend == 3'd0) saw_zero = 1'b1;
    end
    checks++;
    if (late_done != 0 || !saw_zero) begin
      failures++; $display("FAIL drain got_done=%0d got_zero=%b exp_done=0 exp_zero=1", late_done, saw_zero);
    end
  endtask

  task automatic test_tick_coincide();
    logic hit, found;
    apply_reset();
    found = 1'b0;
    for (int e = 0; e < 150 && !found; e++) begin
      hit = (m_op == OP_IDLE) && (m_timer == REF_INTERVAL - 1) && (m_pend == 2);
      Req = !hit; ReqnWE = 1'($urandom_range(0, 1)); ReqAddr = 23'($urandom);
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL coin_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      if (hit) begin
        found = 1'b1;
        checks++;
        if (!(RefPend == 3'd2 && !nCAS0 && !nCAS1 && nRAS && !Ready)) begin
          failures++; $display("FAIL coin_pend got=%h exp_pend=2", obs);
        end
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL coin_reached got=0 exp=1");
    end
    Req = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL coin_tail got=%h exp=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_req_vs_refresh();
    logic hit, found;
    logic [10:0] row;
    apply_reset();
    found = 1'b0; row = '0;
    for (int e = 0; e < 150 && !found; e++) begin
      hit = (m_op == OP_IDLE) && (m_pend == 3);
      Req = 1'b1; ReqnWE = 1'b1; ReqAddr = 23'($urandom);
      row = ReqAddr[21:11];
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rvr_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      if (hit) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL rvr_reached got=0 exp=1");
    end else if (!(nCAS0 && nCAS1 && RA == row && RefPend == 3'd3 && !Ready)) begin
      failures++; $display("FAIL rvr_access_first got=%h row=%h", obs, row);
    end
    Req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rvr_tail k=%0d got=%h exp=%h", k, obs, exp_v);
      end
      if (k == 6 && found) begin
        checks++;
        if (!(Ready && !Done)) begin
          failures++; $display("FAIL rvr_idle got=%h exp_ready=1", obs);
        end
      end
      if (k == 7 && found) begin
        checks++;
        if (!(!nCAS0 && !nCAS1 && nRAS && RefPend == 3'd2)) begin
          failures++; $display("FAIL rvr_refresh got=%h exp_pend=2", obs);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [22:0] addr2;
    int done_cnt;
    apply_reset();
    Req = 1'b1; ReqnWE = 1'b1; ReqAddr = 23'($urandom);
    for (int e = 0; e < 4; e++) begin
      step();
      Req = 1'b0;
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mid_model e=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
    #2 nRES = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++; $display("FAIL mid_abort got=%h exp=%h", obs, RST_VEC);
    end
    Req = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (obs !== RST_VEC) begin
        failures++; $display("FAIL mid_hold got=%h exp=%h", obs, RST_VEC);
      end
    end
    addr2 = 23'($urandom);
    ReqnWE = 1'b0; ReqAddr = addr2;
    @(negedge C7M);
    nRES = 1'b1;
    step();
    Req = 1'b0;
    checks++;
    if (!(RA == addr2[21:11] && !Ready && nRAS && nCAS0 && nCAS1 && !Done)) begin
      failures++; $display("FAIL mid_first_accept got=%h row=%h", obs, addr2[21:11]);
    end
    done_cnt = 0;
    repeat (6) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL mid_after got=%h exp=%h", obs, exp_v);
      end
      if (Done) done_cnt++;
    end
    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL mid_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_random();
    int unsigned dens;
    logic [10:0] col;
    apply_reset();
    dens = 50;
    for (int e = 0; e < 1500; e++) begin
      if (e % 100 == 0) dens = $urandom_range(0, 100);
      Req = ($urandom_range(0, 99) < dens);
      ReqnWE = 1'($urandom_range(0, 1));
      ReqAddr = 23'($urandom);
      step();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rand_model e=%0d got=%h exp=%h st=%0d", e, obs, exp_v, state_dbg);
      end
      // scoreboard: each completed access must present its own column
      if (m_op == OP_ACC && m_phase == 0) exp_q.push_back(m_addr[10:0]);
      if (Done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_sb_empty got=Done exp=none");
        end else begin
          col = exp_q.pop_front();
          if (RA !== col) begin
            failures++; $display("FAIL rand_sb_col got=%h exp=%h", RA, col);
          end
        end
      end
      if (e == 777) begin
        #2 nRES = 1'b0;
        exp_q.delete();
        @(negedge C7M);
        nRES = 1'b1;
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_saturation();
    test_tick_coincide();
    test_req_vs_refresh();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
